// File: rtl/multicycle_cu.sv
// multicycle_cu
//   Control unit for a multicycle load/store CPU. A single FSM walks each
//   instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the
//   datapath write strobes and mux selects for each step, and it traps on an
//   illegal opcode or on a memory handshake that takes too long.
//
// Ports
//   clk_i          sole clock, rising edge
//   rst_i          asynchronous active-high reset
//   enable_i       1 = FSM advances; 0 = hold, write strobes forced low
//   opcode_i       opcode field from the instruction register
//   mem_ready_i    memory completes the current request this cycle
//   zero_i         ALU zero flag, used by BEQ in EXEC
//   pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o,
//   branch_o, jump_o                 datapath strobes
//   reg_dst_o, alu_src_o, mem_to_reg_o  datapath mux selects
//   alu_op_o       00 add, 01 sub/compare, 10 funct-decoded
//   state_o        current FSM state code
//   trap_o         1 while in TRAP
//   trap_cause_o   0 = illegal opcode, 1 = bus timeout
module multicycle_cu #(
  parameter int             OPW      = 4,
  parameter logic [OPW-1:0] OP_R     = OPW'(6),
  parameter logic [OPW-1:0] OP_ADDI  = OPW'(1),
  parameter logic [OPW-1:0] OP_LW    = OPW'(2),
  parameter logic [OPW-1:0] OP_SW    = OPW'(3),
  parameter logic [OPW-1:0] OP_BEQ   = OPW'(4),
  parameter logic [OPW-1:0] OP_J     = OPW'(5),
  parameter int             WAIT_MAX = 15
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           enable_i,
  input  logic [OPW-1:0] opcode_i,
  input  logic           mem_ready_i,
  input  logic           zero_i,
  output logic           pc_write_o,
  output logic           ir_write_o,
  output logic           reg_write_o,
  output logic           mem_read_o,
  output logic           mem_write_o,
  output logic           branch_o,
  output logic           jump_o,
  output logic           reg_dst_o,
  output logic           alu_src_o,
  output logic           mem_to_reg_o,
  output logic [1:0]     alu_op_o,
  output logic [2:0]     state_o,
  output logic           trap_o,
  output logic           trap_cause_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // A timeout fires on the wait cycle that would bring the counter to
  // WAIT_MAX, so compare against the value one below it.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           cause_q, cause_d;

  logic pc_write, ir_write, reg_write, mem_read, mem_write, branch, jump;
  logic reg_dst, alu_src, mem_to_reg;
  logic [1:0] alu_op;

  function automatic logic is_legal(input logic [OPW-1:0] op);
    return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
      cause_q <= 1'b0;
    end else if (enable_i) begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready_i) begin
          // Instruction and PC update happen in the completing cycle itself.
          pc_write = 1'b1;
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DECODE: begin
        op_d = opcode_i;
        if (is_legal(opcode_i)) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 1'b0;
        end
      end

      S_EXEC: begin
        if (op_q == OP_R) begin
          alu_op  = 2'b10;
          state_d = S_WB;
        end else if (op_q == OP_ADDI) begin
          alu_src = 1'b1;
          state_d = S_WB;
        end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
          alu_src = 1'b1;
          state_d = S_MEM;
        end else if (op_q == OP_BEQ) begin
          alu_op   = 2'b01;
          branch   = 1'b1;
          pc_write = zero_i;
          state_d  = S_FETCH;
        end else begin
          // Only J can remain here; DECODE filters illegal opcodes.
          jump     = 1'b1;
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_MEM: begin
        if (op_q == OP_LW) mem_read  = 1'b1;
        else               mem_write = 1'b1;
        if (mem_ready_i) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_R);
        mem_to_reg = (op_q == OP_LW);
        state_d    = S_FETCH;
      end

      S_TRAP: begin
        // Sticky until reset.
      end

      default: state_d = S_FETCH;
    endcase

    // Every fresh FETCH or MEM visit starts its wait budget from zero.
    if (state_d != state_q) cnt_d = '0;
  end

  // Write strobes need both Enable and no reset; everything else only needs
  // reset gating so the outputs fall to zero the instant reset is asserted.
  logic wr_en;
  assign wr_en = enable_i & ~rst_i;

  assign pc_write_o   = pc_write  & wr_en;
  assign ir_write_o   = ir_write  & wr_en;
  assign reg_write_o  = reg_write & wr_en;
  assign mem_write_o  = mem_write & wr_en;
  assign mem_read_o   = mem_read  & ~rst_i;
  assign branch_o     = branch    & ~rst_i;
  assign jump_o       = jump      & ~rst_i;
  assign reg_dst_o    = reg_dst   & ~rst_i;
  assign alu_src_o    = alu_src   & ~rst_i;
  assign mem_to_reg_o = mem_to_reg & ~rst_i;
  assign alu_op_o     = alu_op & {2{~rst_i}};
  assign state_o      = state_q;
  assign trap_o       = (state_q == S_TRAP) & ~rst_i;
  assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_multicycle_cu.sv
module tb_multicycle_cu;

  logic       clk = 1'b0;
  logic       rst, enable, mem_ready, zero;
  logic [3:0] opcode;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, branch, jump;
  logic       reg_dst, alu_src, mem_to_reg, trap, trap_cause;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic [12:0] outs;

  int n_cmp = 0;
  int n_bad = 0;

  // Bit order: PCW IRW RW MR MW BR J | RD AS MTR | AO[1:0] | TRAP
  assign outs = {pc_write, ir_write, reg_write, mem_read, mem_write, branch, jump,
                 reg_dst, alu_src, mem_to_reg, alu_op, trap};

  localparam logic [12:0] O_NONE   = 13'b0000000_000_00_0;
  localparam logic [12:0] O_FET_RD = 13'b1101000_000_00_0;
  localparam logic [12:0] O_FET_WT = 13'b0001000_000_00_0;
  localparam logic [12:0] O_EX_R   = 13'b0000000_000_10_0;
  localparam logic [12:0] O_EX_IMM = 13'b0000000_010_00_0;
  localparam logic [12:0] O_WB_R   = 13'b0010000_100_00_0;
  localparam logic [12:0] O_WB_LW  = 13'b0010000_001_00_0;
  localparam logic [12:0] O_WB_AI  = 13'b0010000_000_00_0;
  localparam logic [12:0] O_MEM_LW = 13'b0001000_000_00_0;
  localparam logic [12:0] O_MEM_SW = 13'b0000100_000_00_0;
  localparam logic [12:0] O_BEQ_T  = 13'b1000010_000_01_0;
  localparam logic [12:0] O_BEQ_NT = 13'b0000010_000_01_0;
  localparam logic [12:0] O_JUMP   = 13'b1000001_000_00_0;
  localparam logic [12:0] O_TRAP   = 13'b0000000_000_00_1;

  multicycle_cu dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .opcode_i(opcode),
    .mem_ready_i(mem_ready), .zero_i(zero),
    .pc_write_o(pc_write), .ir_write_o(ir_write), .reg_write_o(reg_write),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .branch_o(branch),
    .jump_o(jump), .reg_dst_o(reg_dst), .alu_src_o(alu_src),
    .mem_to_reg_o(mem_to_reg), .alu_op_o(alu_op), .state_o(state),
    .trap_o(trap), .trap_cause_o(trap_cause)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0; enable = 1'b1;
    #1;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (outs !== O_NONE) begin n_bad++; $display("FAIL reset_outs: got %b want %b", outs, O_NONE); end
    n_cmp++; if (trap_cause !== 1'b0) begin n_bad++; $display("FAIL reset_cause: got %b want 0", trap_cause); end
    rst = 1'b0;
    #1;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL release_state: got %0d want 0", state); end
    n_cmp++; if (outs !== O_FET_WT) begin n_bad++; $display("FAIL release_outs: got %b want %b", outs, O_FET_WT); end
  endtask

  task automatic test_rtype();
    logic [2:0]  es [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic [12:0] eo [5] = '{O_FET_RD, O_NONE, O_EX_R, O_WB_R, O_FET_RD};
    opcode = 4'd6; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, es[i]); end
      n_cmp++; if (outs !== eo[i]) begin n_bad++; $display("FAIL rtype_outs[%0d]: got %b want %b", i, outs, eo[i]); end
      if (i < 4) tick();
    end
  endtask

  task automatic test_lw();
    logic        rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0]  es  [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    logic [12:0] eo  [9] = '{O_FET_RD, O_NONE, O_EX_IMM, O_MEM_LW, O_MEM_LW,
                             O_MEM_LW, O_MEM_LW, O_WB_LW, O_FET_RD};
    opcode = 4'd2;
    for (int i = 0; i < 9; i++) begin
      mem_ready = rdy[i];
      #1;
      n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, es[i]); end
      n_cmp++; if (outs !== eo[i]) begin n_bad++; $display("FAIL lw_outs[%0d]: got %b want %b", i, outs, eo[i]); end
      if (i < 8) tick();
    end
  endtask

  task automatic test_addi();
    logic [2:0]  es [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic [12:0] eo [5] = '{O_FET_RD, O_NONE, O_EX_IMM, O_WB_AI, O_FET_RD};
    opcode = 4'd1; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, state, es[i]); end
      n_cmp++; if (outs !== eo[i]) begin n_bad++; $display("FAIL addi_outs[%0d]: got %b want %b", i, outs, eo[i]); end
      if (i < 4) tick();
    end
  endtask

  task automatic test_beq();
    logic        zf [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0]  es [7] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    logic [12:0] eo [7] = '{O_FET_RD, O_NONE, O_BEQ_T, O_FET_RD, O_NONE, O_BEQ_NT, O_FET_RD};
    opcode = 4'd4; mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      zero = zf[i];
      #1;
      n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL beq_state[%0d]: got %0d want %0d", i, state, es[i]); end
      n_cmp++; if (outs !== eo[i]) begin n_bad++; $display("FAIL beq_outs[%0d]: got %b want %b", i, outs, eo[i]); end
      if (i < 6) tick();
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [2:0]  es [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
    logic [12:0] eo [4] = '{O_FET_RD, O_NONE, O_JUMP, O_FET_RD};
    opcode = 4'd5; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (state !== es[i]) begin n_bad++; $display("FAIL jump_state[%0d]: got %0d want %0d", i, state, es[i]); end
      n_cmp++; if (outs !== eo[i]) begin n_bad++; $display("FAIL jump_outs[%0d]: got %b want %b", i, outs, eo[i]); end
      if (i < 3) tick();
    end
  endtask

  task automatic test_illegal();
    opcode = 4'd15; mem_ready = 1'b1;
    #1;
    n_cmp++; if (outs !== O_FET_RD) begin n_bad++; $display("FAIL ill_fetch: got %b want %b", outs, O_FET_RD); end
    tick(); #1;
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL ill_decode: got %0d want 1", state); end
    tick(); #1;
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL ill_state: got %0d want 5", state); end
    n_cmp++; if (outs !== O_TRAP) begin n_bad++; $display("FAIL ill_outs: got %b want %b", outs, O_TRAP); end
    n_cmp++; if (trap_cause !== 1'b0) begin n_bad++; $display("FAIL ill_cause: got %b want 0", trap_cause); end
    mem_ready = 1'b0; opcode = 4'd6;
    for (int i = 0; i < 3; i++) tick();
    #1;
    n_cmp++; if (state !== 3'd5 || trap !== 1'b1) begin n_bad++; $display("FAIL ill_hold: got state %0d trap %b want 5/1", state, trap); end
  endtask

  task automatic test_timeout();
    // FETCH: 15 cycles of no response traps with bus-timeout cause.
    for (int i = 0; i < 15; i++) begin
      mem_ready = 1'b0;
      #1;
      n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL to_fetch_wait[%0d]: got %0d want 0", i, state); end
      tick();
    end
    #1;
    n_cmp++; if (state !== 3'd5 || trap !== 1'b1) begin n_bad++; $display("FAIL to_fetch_trap: got state %0d trap %b want 5/1", state, trap); end
    n_cmp++; if (trap_cause !== 1'b1) begin n_bad++; $display("FAIL to_fetch_cause: got %b want 1", trap_cause); end
    test_reset();
    // MemReady on the 15th cycle wins over the timeout.
    for (int i = 0; i < 14; i++) tick();
    mem_ready = 1'b1;
    #1;
    n_cmp++; if (outs !== O_FET_RD) begin n_bad++; $display("FAIL to_last_ready: got %b want %b", outs, O_FET_RD); end
    opcode = 4'd3;
    tick(); #1;
    n_cmp++; if (state !== 3'd1 || trap_cause !== 1'b0) begin n_bad++; $display("FAIL to_no_trap: got state %0d cause %b want 1/0", state, trap_cause); end
    // MEM: SW that never completes.
    tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (i == 14) begin
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL to_mem_wait: got %0d want 3", state); end
      end
      tick();
    end
    #1;
    n_cmp++; if (state !== 3'd5 || trap_cause !== 1'b1) begin n_bad++; $display("FAIL to_mem_trap: got state %0d cause %b want 5/1", state, trap_cause); end
    test_reset();
  endtask

  task automatic test_enable_hold();
    opcode = 4'd3; mem_ready = 1'b1;
    #1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    n_cmp++; if (state !== 3'd3 || outs !== O_MEM_SW) begin n_bad++; $display("FAIL hold_enter: got state %0d outs %b want 3/%b", state, outs, O_MEM_SW); end
    enable = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (state !== 3'd3 || mem_write !== 1'b0) begin n_bad++; $display("FAIL hold_cycle[%0d]: got state %0d mw %b want 3/0", i, state, mem_write); end
      tick();
    end
    enable = 1'b1; mem_ready = 1'b0;
    #1;
    n_cmp++; if (state !== 3'd3 || outs !== O_MEM_SW) begin n_bad++; $display("FAIL hold_resume: got state %0d outs %b want 3/%b", state, outs, O_MEM_SW); end
    rst = 1'b1;
    #1;
    n_cmp++; if (state !== 3'd0 || outs !== O_NONE) begin n_bad++; $display("FAIL hold_reset: got state %0d outs %b want 0/%b", state, outs, O_NONE); end
    rst = 1'b0;
    #1;
    n_cmp++; if (outs !== O_FET_WT) begin n_bad++; $display("FAIL hold_release: got %b want %b", outs, O_FET_WT); end
    // Disabled FETCH ignores MemReady and keeps write strobes low.
    enable = 1'b0; mem_ready = 1'b1;
    #1;
    n_cmp++; if (outs !== O_FET_WT) begin n_bad++; $display("FAIL hold_fetch_outs: got %b want %b", outs, O_FET_WT); end
    tick(); #1;
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL hold_fetch_state: got %0d want 0", state); end
    enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 4'd0;
    test_reset();
    test_rtype();
    test_lw();
    test_addi();
    test_beq();
    test_jump();
    test_illegal();
    test_reset();
    test_timeout();
    test_enable_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
